// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      FLUSH,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
   parameter int AW = 17,
   parameter int DW = 32
) ();

   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [DW-1:0] imem_wdata;

   // Loader side
   modport master (
      input  rx_valid, rx_data,
      output rx_ready, imem_we, imem_waddr, imem_wdata
   );

   // Stream source / memory side
   modport slave (
      output rx_valid, rx_data,
      input  rx_ready, imem_we, imem_waddr, imem_wdata
   );

endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian word image into instruction memory
// and keeps the core in reset until the image is complete.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int IMEM_DEPTH = 131072,
   parameter int PROG_VALUE = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   imem_loader_if.master   bus,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            core_hold
);

   localparam int AW = $clog2(IMEM_DEPTH);

   state_t                state_q, state_d;
   logic [1:0]            byte_cnt_q;
   logic [31:0]           word_cnt_q;
   logic [31:0]           n_q;
   // The low byte of the 32-bit assembler is shifted out before it is ever
   // read, so only the upper three bytes are held; sr_d is the full word.
   logic [WORD_W-9:0]     pend_q;
   logic [WORD_W-1:0]     sr_d;
   logic                  we_q;
   logic [AW-1:0]         waddr_q;
   logic [PROG_VALUE-1:0] wdata_q;

   logic ready_c;
   logic start_ok;
   logic xfer;
   logic word_end;
   logic last_word;
   logic len_bad;

   assign sr_d      = {bus.rx_data, pend_q};
   assign word_end  = bus.rx_valid && (byte_cnt_q == 2'd3);
   assign last_word = (word_cnt_q == (n_q - 32'd1));
   assign len_bad   = (sr_d == '0) || (sr_d > 32'(IMEM_DEPTH));
   assign xfer      = bus.rx_valid && ready_c;

   assign bus.rx_ready   = ready_c;
   assign bus.imem_we    = we_q;
   assign bus.imem_waddr = waddr_q;
   assign bus.imem_wdata = wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ready_c   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      core_hold = 1'b1;
      start_ok  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               start_ok = 1'b1;
               state_d  = LEN;
            end
         end
         LEN: begin
            ready_c = 1'b1;
            busy    = 1'b1;
            if (word_end) begin
               state_d = len_bad ? ERR : DATA;
            end
         end
         DATA: begin
            ready_c = 1'b1;
            busy    = 1'b1;
            if (word_end && last_word) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            busy    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done      = 1'b1;
            core_hold = 1'b0;
            if (start) begin
               start_ok = 1'b1;
               state_d  = LEN;
            end
         end
         ERR: begin
            err = 1'b1;
            if (start) begin
               start_ok = 1'b1;
               state_d  = LEN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_q <= '0;
         word_cnt_q <= '0;
         n_q        <= '0;
         pend_q     <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
      end else begin
         we_q <= 1'b0;
         if (start_ok) begin
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            waddr_q    <= '0;
         end else if (xfer) begin
            pend_q     <= sr_d[WORD_W-1:8];
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
               if (state_q == LEN) begin
                  n_q <= sr_d;
               end else begin
                  // Address comes from the word count so it never wraps
                  // even when the image fills the whole memory.
                  we_q       <= 1'b1;
                  wdata_q    <= sr_d;
                  waddr_q    <= word_cnt_q[AW-1:0];
                  word_cnt_q <= word_cnt_q + 32'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench: full-size loader plus a reduced-depth one.
module tb_imem_loader;

   localparam int DEPTH0 = 131072;
   localparam int AW0    = 17;
   localparam int DEPTH1 = 8;
   localparam int AW1    = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   logic busy0, done0, err0, hold0;
   logic busy1, done1, err1, hold1;

   imem_loader_if #(.AW(AW0), .DW(32)) bus0 ();
   imem_loader_if #(.AW(AW1), .DW(32)) bus1 ();

   imem_loader #(.IMEM_DEPTH(DEPTH0), .PROG_VALUE(32)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .bus(bus0),
      .busy(busy0), .done(done0), .err(err0), .core_hold(hold0)
   );

   imem_loader #(.IMEM_DEPTH(DEPTH1), .PROG_VALUE(32)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1),
      .busy(busy1), .done(done1), .err(err1), .core_hold(hold1)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int          wa0[$], wa1[$];
   logic [31:0] wd0[$], wd1[$];
   logic [31:0] img[16];

   // Record every memory write, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n && bus0.imem_we) begin
         wa0.push_back(int'(bus0.imem_waddr));
         wd0.push_back(bus0.imem_wdata);
      end
      if (rst_n && bus1.imem_we) begin
         wa1.push_back(int'(bus1.imem_waddr));
         wd1.push_back(bus1.imem_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {busy, done, err, core_hold, rx_ready, imem_we}
   function automatic logic [5:0] flags(input int d);
      if (d == 0) return {busy0, done0, err0, hold0, bus0.rx_ready, bus0.imem_we};
      return {busy1, done1, err1, hold1, bus1.rx_ready, bus1.imem_we};
   endfunction

   function automatic logic rdy(input int d);
      return (d == 0) ? bus0.rx_ready : bus1.rx_ready;
   endfunction

   task automatic set_in(input int d, input logic v, input logic [7:0] b);
      if (d == 0) begin
         bus0.rx_valid = v;
         bus0.rx_data  = b;
      end else begin
         bus1.rx_valid = v;
         bus1.rx_data  = b;
      end
   endtask

   task automatic send_byte(input int d, input logic [7:0] b, input bit gaps);
      int guard;
      if (gaps) begin
         set_in(d, 1'b0, 8'h00);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      set_in(d, 1'b1, b);
      guard = 0;
      while (!rdy(d) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("rx_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      set_in(d, 1'b0, 8'h00);
   endtask

   task automatic send_word(input int d, input logic [31:0] w, input bit gaps);
      for (int i = 0; i < 4; i++) send_byte(d, w[8*i +: 8], gaps);
   endtask

   task automatic pulse_start(input int d);
      if (d == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic load(input int d, input logic [31:0] hdr, input int n, input bit gaps);
      send_word(d, hdr, gaps);
      for (int i = 0; i < n; i++) send_word(d, img[i], gaps);
   endtask

   // Called in the cycle right after the final byte transferred
   task automatic flush_then_done(input int d, input string tag);
      check({tag, "_flush"}, 32'(flags(d)), 32'b100101);
      @(negedge clk);
      check({tag, "_done"}, 32'(flags(d)), 32'b010000);
   endtask

   task automatic check_writes(input int d, input int n);
      int          qa[$];
      logic [31:0] qd[$];
      #1;
      if (d == 0) begin
         qa = wa0; qd = wd0; wa0.delete(); wd0.delete();
      end else begin
         qa = wa1; qd = wd1; wa1.delete(); wd1.delete();
      end
      check($sformatf("wr_count_d%0d", d), 32'(qa.size()), 32'(n));
      for (int i = 0; i < n && i < qa.size(); i++) begin
         check($sformatf("wr%0d_addr_d%0d", i, d), 32'(qa[i]), 32'(i));
         check($sformatf("wr%0d_data_d%0d", i, d), qd[i], img[i]);
      end
   endtask

   initial begin
      set_in(0, 1'b0, 8'h00);
      set_in(1, 1'b0, 8'h00);
      repeat (2) @(negedge clk);
      check("rst_flags0", 32'(flags(0)), 32'b000100);
      check("rst_flags1", 32'(flags(1)), 32'b000100);
      check("rst_waddr0", 32'(bus0.imem_waddr), 32'd0);
      check("rst_wdata0", bus0.imem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_flags", 32'(flags(0)), 32'b000100);

      // Two-word image at full rate
      pulse_start(0);
      check("len_flags", 32'(flags(0)), 32'b100110);
      img[0] = 32'h12345678;
      img[1] = 32'hDEADBEEF;
      load(0, 32'd2, 2, 1'b0);
      check("n2_last_addr", 32'(bus0.imem_waddr), 32'd1);
      check("n2_last_data", bus0.imem_wdata, 32'hDEADBEEF);
      flush_then_done(0, "n2");
      check_writes(0, 2);

      // Four words with random gaps on rx_valid
      pulse_start(0);
      check("restart_flags", 32'(flags(0)), 32'b100110);
      img[0] = 32'h0A0B0C0D;
      img[1] = 32'hFFFFFFFF;
      img[2] = 32'h00000000;
      img[3] = 32'h80000001;
      load(0, 32'd4, 4, 1'b1);
      flush_then_done(0, "n4");
      check_writes(0, 4);

      // Zero-length header, then a valid one-word image
      pulse_start(0);
      load(0, 32'd0, 0, 1'b0);
      check("zero_len_err", 32'(flags(0)), 32'b001100);
      repeat (2) @(negedge clk);
      check("zero_len_hold", 32'(flags(0)), 32'b001100);
      check_writes(0, 0);
      pulse_start(0);
      check("err_cleared", 32'(flags(0)), 32'b100110);
      img[0] = 32'hCAFEF00D;
      load(0, 32'd1, 1, 1'b0);
      flush_then_done(0, "after_err");
      check_writes(0, 1);

      // Length just over the memory depth
      pulse_start(0);
      load(0, 32'(DEPTH0 + 1), 0, 1'b0);
      check("over_depth_err0", 32'(flags(0)), 32'b001100);
      check_writes(0, 0);
      pulse_start(1);
      load(1, 32'(DEPTH1 + 1), 0, 1'b0);
      check("over_depth_err1", 32'(flags(1)), 32'b001100);

      // Image exactly filling the reduced-depth memory
      pulse_start(1);
      for (int i = 0; i < DEPTH1; i++) img[i] = {8'hA5, 8'(i), 8'h5A, 8'(3 * i)};
      load(1, 32'(DEPTH1), DEPTH1, 1'b1);
      flush_then_done(1, "full_depth");
      check_writes(1, DEPTH1);

      // Asynchronous reset mid-load
      pulse_start(0);
      img[0] = 32'h01020304;
      img[1] = 32'h05060708;
      load(0, 32'd3, 2, 1'b0);
      send_byte(0, 8'hAA, 1'b0);
      send_byte(0, 8'hBB, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_flags", 32'(flags(0)), 32'b000100);
      check("async_rst_waddr", 32'(bus0.imem_waddr), 32'd0);
      check("async_rst_wdata", bus0.imem_wdata, 32'd0);
      check_writes(0, 2);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start(0);
      img[0] = 32'h0BADC0DE;
      load(0, 32'd1, 1, 1'b0);
      flush_then_done(0, "post_rst");
      check_writes(0, 1);

      // start during DATA is ignored; start in DONE reloads from address 0
      pulse_start(0);
      img[0] = 32'h11111111;
      img[1] = 32'h22222222;
      send_word(0, 32'd2, 1'b0);
      send_word(0, img[0], 1'b0);
      pulse_start(0);
      check("start_in_data", 32'(flags(0)), 32'b100110);
      send_word(0, img[1], 1'b0);
      flush_then_done(0, "ign_start");
      check_writes(0, 2);
      pulse_start(0);
      check("reload_flags", 32'(flags(0)), 32'b100110);
      img[0] = 32'h33333333;
      load(0, 32'd1, 1, 1'b0);
      flush_then_done(0, "reload");
      check_writes(0, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
